// File: rtl/spi_master_irq_ctrl.sv
// rtl/spi_master_irq_ctrl.sv - per-channel FIFO threshold interrupts with count/status-read re-arm and sticky EOT status
module spi_master_irq_ctrl #(
   parameter int NUM_CH    = 2,
   parameter int CNT_WIDTH = 5
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_elements_i,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_th_i,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_cnt_i,
   input  logic [NUM_CH-1:0]             ch_dir_i,
   input  logic [NUM_CH-1:0]             ch_xfer_i,
   input  logic [NUM_CH-1:0]             int_en_i,
   input  logic                          cnt_en_i,
   input  logic                          level_mode_i,
   input  logic                          eot_i,
   input  logic                          sta_rd_i,
   input  logic [NUM_CH:0]               clr_i,
   output logic                          irq_o,
   output logic                          eot_evt_o,
   output logic [NUM_CH:0]               sta_o,
   output logic [NUM_CH-1:0]             armed_o
);

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_FIRE  = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [NUM_CH-1:0] w_fire;
   logic [NUM_CH-1:0] w_armed;
   logic [NUM_CH-1:0] w_set;
   logic [NUM_CH:0]   r_sta;
   logic              r_eot_evt;

   genvar gi;
   for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t               r_state;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] w_el;
      logic [CNT_WIDTH-1:0] w_th;
      logic [CNT_WIDTH-1:0] w_cnt_cfg;
      logic [CNT_WIDTH-1:0] w_cnt_eff;
      logic [CNT_WIDTH:0]   w_cnt_m1;
      logic                 w_cond;
      logic                 w_last;
      logic                 w_rearm;

      assign w_el      = ch_elements_i[gi*CNT_WIDTH +: CNT_WIDTH];
      assign w_th      = ch_th_i[gi*CNT_WIDTH +: CNT_WIDTH];
      assign w_cnt_cfg = ch_cnt_i[gi*CNT_WIDTH +: CNT_WIDTH];
      assign w_cond    = ch_dir_i[gi] ? (w_el >= w_th) : (w_el <= w_th);
      // A programmed count of 0 behaves like 1 so the cnt-1 compare never underflows
      assign w_cnt_eff = (w_cnt_cfg == '0) ? CNT_WIDTH'(1) : w_cnt_cfg;
      assign w_cnt_m1  = {1'b0, w_cnt_eff} - (CNT_WIDTH+1)'(1);
      assign w_last    = ({1'b0, r_cnt} == w_cnt_m1);
      assign w_rearm   = cnt_en_i ? (ch_xfer_i[gi] && w_last) : sta_rd_i;

      // Transfer counter: runs in every state while counting is enabled, wraps at cnt-1
      always_ff @(posedge HCLK) begin
         if (!HRESETn || !cnt_en_i) begin
            r_cnt <= '0;
         end else if (ch_xfer_i[gi]) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
         end
      end

      // Channel FSM; disabling the channel forces ARMED ahead of everything else
      always_ff @(posedge HCLK) begin
         if (!HRESETn || !int_en_i[gi]) begin
            r_state <= ST_ARMED;
         end else begin
            case (r_state)
               ST_ARMED: if (w_cond) r_state <= ST_FIRE;
               ST_FIRE:  r_state <= ST_WAIT;
               ST_WAIT:  if (w_rearm) r_state <= ST_ARMED;
               default:  r_state <= ST_ARMED;
            endcase
         end
      end

      assign w_fire[gi]  = (r_state == ST_FIRE);
      assign w_armed[gi] = (r_state == ST_ARMED);
      assign w_set[gi]   = int_en_i[gi] && (r_state == ST_ARMED) && w_cond;
   end

   // Sticky status (set beats clear) and one-cycle delayed EOT event
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_sta     <= '0;
         r_eot_evt <= 1'b0;
      end else begin
         r_sta     <= (r_sta & ~clr_i) | {eot_i, w_set};
         r_eot_evt <= eot_i;
      end
   end

   assign irq_o     = level_mode_i ? (|r_sta) : ((|w_fire) | r_eot_evt);
   assign eot_evt_o = r_eot_evt;
   assign sta_o     = r_sta;
   assign armed_o   = w_armed;

endmodule

// File: tb/tb_spi_master_irq_ctrl.sv
// tb/tb_spi_master_irq_ctrl.sv - directed and randomized checks of spi_master_irq_ctrl against a behavioural model
module tb_spi_master_irq_ctrl;

   localparam int NCH = 2;
   localparam int CW  = 5;

   logic              HCLK = 1'b0;
   logic              HRESETn;
   logic [NCH*CW-1:0] ch_elements_i, ch_th_i, ch_cnt_i;
   logic [NCH-1:0]    ch_dir_i, ch_xfer_i, int_en_i;
   logic              cnt_en_i, level_mode_i, eot_i, sta_rd_i;
   logic [NCH:0]      clr_i;
   logic              irq_o, eot_evt_o;
   logic [NCH:0]      sta_o;
   logic [NCH-1:0]    armed_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: per channel "armed" and "firing" flags (neither = waiting), transfer tally
   bit           m_armed [NCH];
   bit           m_fire  [NCH];
   int           m_cnt   [NCH];
   logic [NCH:0] m_sta;
   bit           m_eot;

   spi_master_irq_ctrl #(.NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .ch_elements_i(ch_elements_i), .ch_th_i(ch_th_i), .ch_cnt_i(ch_cnt_i),
      .ch_dir_i(ch_dir_i), .ch_xfer_i(ch_xfer_i), .int_en_i(int_en_i),
      .cnt_en_i(cnt_en_i), .level_mode_i(level_mode_i), .eot_i(eot_i),
      .sta_rd_i(sta_rd_i), .clr_i(clr_i),
      .irq_o(irq_o), .eot_evt_o(eot_evt_o), .sta_o(sta_o), .armed_o(armed_o)
   );

   always #5 HCLK = ~HCLK;

   function automatic bit cond(int c);
      int el = int'(ch_elements_i[c*CW +: CW]);
      int th = int'(ch_th_i[c*CW +: CW]);
      return ch_dir_i[c] ? (el >= th) : (el <= th);
   endfunction

   function automatic int eff_cnt(int c);
      int n = int'(ch_cnt_i[c*CW +: CW]);
      return (n == 0) ? 1 : n;
   endfunction

   function automatic bit wraps(int c);
      return cnt_en_i && ch_xfer_i[c] && (m_cnt[c] == eff_cnt(c) - 1);
   endfunction

   function automatic logic [NCH-1:0] fires_now();
      logic [NCH-1:0] s = '0;
      for (int c = 0; c < NCH; c++) s[c] = int_en_i[c] && m_armed[c] && cond(c);
      return s;
   endfunction

   always @(posedge HCLK) begin
      if (!HRESETn) begin
         for (int c = 0; c < NCH; c++) begin
            m_armed[c] <= 1'b1;
            m_fire[c]  <= 1'b0;
            m_cnt[c]   <= 0;
         end
         m_sta <= '0;
         m_eot <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (!cnt_en_i)         m_cnt[c] <= 0;
            else if (wraps(c))     m_cnt[c] <= 0;
            else if (ch_xfer_i[c]) m_cnt[c] <= (m_cnt[c] + 1) % (1 << CW);
            if (!int_en_i[c]) begin
               m_armed[c] <= 1'b1;
               m_fire[c]  <= 1'b0;
            end else if (m_armed[c]) begin
               m_fire[c]  <= cond(c);
               m_armed[c] <= !cond(c);
            end else if (m_fire[c]) begin
               m_fire[c]  <= 1'b0;
            end else begin
               m_armed[c] <= cnt_en_i ? wraps(c) : sta_rd_i;
            end
         end
         m_sta <= (m_sta & ~clr_i) | {eot_i, fires_now()};
         m_eot <= eot_i;
      end
   end

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Every cycle: DUT outputs against the model
   always @(negedge HCLK) begin
      if (chk_en) begin
         logic [NCH-1:0] ea;
         bit anyf;
         anyf = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            ea[c] = m_armed[c];
            anyf  = anyf | m_fire[c];
         end
         cmp("model_armed", 32'(armed_o), 32'(ea));
         cmp("model_sta", 32'(sta_o), 32'(m_sta));
         cmp("model_eot_evt", 32'(eot_evt_o), 32'(m_eot));
         cmp("model_irq", 32'(irq_o), 32'(level_mode_i ? |m_sta : (anyf | m_eot)));
      end
   end

   task automatic step();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic set_ch(int c, int el, int th, int cnt, bit dir);
      ch_elements_i[c*CW +: CW] = CW'(el);
      ch_th_i[c*CW +: CW]       = CW'(th);
      ch_cnt_i[c*CW +: CW]      = CW'(cnt);
      ch_dir_i[c]               = dir;
   endtask

   task automatic xfer_pulse(int c);
      ch_xfer_i[c] = 1'b1;
      step();
      ch_xfer_i = '0;
   endtask

   initial begin
      HRESETn = 1'b0;
      ch_elements_i = '0; ch_th_i = '0; ch_cnt_i = '0;
      ch_dir_i = '0; ch_xfer_i = '0; int_en_i = '0;
      cnt_en_i = 1'b0; level_mode_i = 1'b0; eot_i = 1'b0; sta_rd_i = 1'b0; clr_i = '0;
      step();
      chk_en = 1'b1;
      cmp("rst_sta", 32'(sta_o), 32'h0);
      cmp("rst_armed", 32'(armed_o), 32'h3);
      cmp("rst_irq", 32'(irq_o), 32'h0);
      cmp("rst_eot_evt", 32'(eot_evt_o), 32'h0);

      // Threshold fire on a TX-type channel
      HRESETn = 1'b1;
      set_ch(0, 5, 2, 0, 1'b0);
      set_ch(1, 0, 4, 0, 1'b1);
      int_en_i = 2'b01;
      step();
      cmp("t1_no_fire_armed", 32'(armed_o), 32'h3);
      ch_elements_i[0 +: CW] = 5'd2;
      step();
      cmp("t1_fire_irq", 32'(irq_o), 32'h1);
      cmp("t1_fire_sta", 32'(sta_o), 32'h1);
      cmp("t1_fire_armed", 32'(armed_o), 32'h2);
      ch_elements_i[0 +: CW] = 5'd5;
      step();
      cmp("t1_wait_irq", 32'(irq_o), 32'h0);
      cmp("t1_wait_armed", 32'(armed_o), 32'h2);

      // Re-arm after three transfers, then with a count of zero
      cnt_en_i = 1'b1;
      ch_cnt_i[0 +: CW] = 5'd3;
      xfer_pulse(0);
      cmp("t2_x1_armed", 32'(armed_o[0]), 32'h0);
      xfer_pulse(0);
      cmp("t2_x2_armed", 32'(armed_o[0]), 32'h0);
      xfer_pulse(0);
      cmp("t2_x3_armed", 32'(armed_o[0]), 32'h1);
      ch_elements_i[0 +: CW] = 5'd2;
      step();
      ch_elements_i[0 +: CW] = 5'd5;
      ch_cnt_i[0 +: CW] = 5'd0;
      step();
      cmp("t2_cnt0_wait", 32'(armed_o[0]), 32'h0);
      xfer_pulse(0);
      cmp("t2_cnt0_rearm", 32'(armed_o[0]), 32'h1);
      clr_i = 3'b001;
      step();
      clr_i = '0;

      // Status-read re-arm on an RX-type channel
      cnt_en_i = 1'b0;
      set_ch(1, 6, 4, 0, 1'b1);
      int_en_i = 2'b11;
      step();
      cmp("t3_fire_armed", 32'(armed_o), 32'h1);
      cmp("t3_fire_sta", 32'(sta_o), 32'h2);
      step();
      xfer_pulse(1);
      cmp("t3_xfer_ignored", 32'(armed_o), 32'h1);
      sta_rd_i = 1'b1;
      step();
      sta_rd_i = 1'b0;
      cmp("t3_rd_rearm", 32'(armed_o), 32'h3);
      step();
      cmp("t3_refire_armed", 32'(armed_o), 32'h1);
      cmp("t3_refire_irq", 32'(irq_o), 32'h1);
      step();
      int_en_i = 2'b01;
      step();
      cmp("t6_dis_rearm", 32'(armed_o), 32'h3);
      ch_elements_i[CW +: CW] = 5'd0;

      // Level mode with sticky status and clears
      level_mode_i = 1'b1;
      clr_i = 3'b111;
      step();
      clr_i = '0;
      ch_elements_i[0 +: CW] = 5'd2;
      eot_i = 1'b1;
      step();
      ch_elements_i[0 +: CW] = 5'd5;
      eot_i = 1'b0;
      cmp("t4_sta_set", 32'(sta_o), 32'h5);
      step();
      cmp("t4_irq_held", 32'(irq_o), 32'h1);
      clr_i = 3'b001;
      step();
      cmp("t4_clr0_sta", 32'(sta_o), 32'h4);
      cmp("t4_clr0_irq", 32'(irq_o), 32'h1);
      clr_i = 3'b100;
      step();
      cmp("t4_clr2_irq", 32'(irq_o), 32'h0);
      eot_i = 1'b1;
      step();
      eot_i = 1'b0;
      clr_i = '0;
      cmp("t4_set_wins", 32'(sta_o[2]), 32'h1);
      clr_i = 3'b111;
      sta_rd_i = 1'b1;
      step();
      clr_i = '0;
      sta_rd_i = 1'b0;
      level_mode_i = 1'b0;
      step();

      // EOT event in pulse mode
      eot_i = 1'b1;
      step();
      eot_i = 1'b0;
      cmp("t5_evt_hi", 32'(eot_evt_o), 32'h1);
      cmp("t5_irq_hi", 32'(irq_o), 32'h1);
      step();
      cmp("t5_evt_lo", 32'(eot_evt_o), 32'h0);
      cmp("t5_irq_lo", 32'(irq_o), 32'h0);

      // Reset during FIRE
      ch_elements_i[0 +: CW] = 5'd2;
      step();
      cmp("t6_fire_irq", 32'(irq_o), 32'h1);
      HRESETn = 1'b0;
      ch_elements_i[0 +: CW] = 5'd5;
      step();
      HRESETn = 1'b1;
      cmp("t6_rst_armed", 32'(armed_o), 32'h3);
      cmp("t6_rst_sta", 32'(sta_o), 32'h0);
      cmp("t6_rst_irq", 32'(irq_o), 32'h0);
      step();
      cmp("t6_no_pulse", 32'(irq_o), 32'h0);

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 15) == 0)
               set_ch(c, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            else
               ch_elements_i[c*CW +: CW] = CW'($urandom_range(0, 31));
            ch_xfer_i[c] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) int_en_i[c] = ~int_en_i[c];
            else if ($urandom_range(0, 9) == 0) int_en_i[c] = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) cnt_en_i = ~cnt_en_i;
         if ($urandom_range(0, 99) == 0) level_mode_i = ~level_mode_i;
         eot_i    = ($urandom_range(0, 9) == 0);
         sta_rd_i = ($urandom_range(0, 9) == 0);
         for (int b = 0; b <= NCH; b++) clr_i[b] = ($urandom_range(0, 9) == 0);
         HRESETn  = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_master_irq_ctrl.md
Name: spi_master_irq_ctrl

Overview:
Parametrised interrupt/event generator for the SPI master. It watches the fill levels and handshakes of NUM_CH FIFOs and raises a threshold interrupt per channel, then re-arms the channel either after a programmed number of transfers or after a status read. It also latches end-of-transfer into a sticky status vector and offers pulse or level interrupt output. It sits between the SPI master FIFOs/controller and the APB register interface, and drives events_o.

Parameters:
NUM_CH, 2, number of monitored FIFO channels (>=1)
CNT_WIDTH, 5, width of element count, threshold and re-arm count fields (LOG_BUFFER_DEPTH+1)

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
ch_elements_i  in  NUM_CH*CNT_WIDTH  FIFO fill level per channel; channel i at [i*CNT_WIDTH +: CNT_WIDTH]
ch_th_i  in  NUM_CH*CNT_WIDTH  threshold per channel
ch_cnt_i  in  NUM_CH*CNT_WIDTH  re-arm transfer count per channel
ch_dir_i  in  NUM_CH  compare direction: 0 = fire when elements<=th (TX-type), 1 = fire when elements>=th (RX-type)
ch_xfer_i  in  NUM_CH  one-cycle FIFO pop/push handshake (valid&&ready)
int_en_i  in  NUM_CH  per-channel interrupt enable
cnt_en_i  in  1  1 = re-arm by transfer count; 0 = re-arm by status read
level_mode_i  in  1  0 = pulse irq_o; 1 = level irq_o from sticky status
eot_i  in  1  end-of-transfer pulse from controller
sta_rd_i  in  1  one-cycle pulse on APB read of interrupt status
clr_i  in  NUM_CH+1  write-1-to-clear for sticky status; bit NUM_CH = EOT
irq_o  out  1  combined interrupt
eot_evt_o  out  1  registered end-of-transfer event
sta_o  out  NUM_CH+1  sticky status; bit i = channel i fired, bit NUM_CH = EOT
armed_o  out  NUM_CH  1 when the channel FSM is in ARMED

Behaviour:
- Interface: one clock, HCLK. Reset HRESETn is synchronous and active-low. On the first rising edge with HRESETn=0: every FSM goes to ARMED, counters go to 0, sta_o=0, eot_evt_o=0, irq_o=0, armed_o=all ones. Reset mid-operation discards pending FIRE and WAIT states.
- Compare: unsigned, CNT_WIDTH bits. cond_i = dir ? (elements>=th) : (elements<=th).
- Per-channel FSM, states ARMED / FIRE / WAIT:
  - ARMED -> FIRE at the edge where int_en_i[i] && cond_i.
  - FIRE lasts exactly 1 cycle, then -> WAIT unconditionally.
  - WAIT with cnt_en_i=1 -> ARMED at the edge where ch_xfer_i[i] && counter_i==ch_cnt_i-1.
  - WAIT with cnt_en_i=0 -> ARMED at the edge where sta_rd_i=1.
  - Any state with int_en_i[i]=0 -> ARMED. This disable-rearm takes priority.
- Re-arm counter_i (CNT_WIDTH bits):
  - Increments on ch_xfer_i[i] while cnt_en_i=1, in every state.
  - Wraps to 0 when counter_i==ch_cnt_i-1.
  - The cnt-1 compare is evaluated in CNT_WIDTH+1 bits. ch_cnt_i=0 is treated as 1: wrap and re-arm on every transfer, no underflow.
  - Held at 0 while cnt_en_i=0.
- sta_o[i] is set on the edge entering FIRE, so it is visible in the FIRE cycle.
- sta_o[NUM_CH] is set on the edge where eot_i=1.
- Clearing: a bit is cleared on the edge where the matching clr_i bit is 1. If set and clear coincide, set wins.
- eot_evt_o = eot_i delayed 1 cycle, one cycle wide.
- irq_o, pulse mode: OR over channels of (state==FIRE), ORed with eot_evt_o.
- irq_o, level mode: |sta_o. Combinational from registers; no extra latency.
- Latency: condition true at edge k -> FIRE and irq_o pulse in cycle k..k+1 -> WAIT after edge k+1.
- Simultaneous events:
  - sta_rd_i in count mode is ignored.
  - A transfer that wraps the counter in the same cycle the channel enters FIRE does not re-arm; only WAIT re-arms.
  - Channels are fully independent; several may FIRE in the same cycle.
- Threshold re-evaluation happens only in ARMED. A condition that is still true after re-arm fires again on the next edge.

Test Plan:
1. Reset; TX-type ch0, th=2, int_en=1, elements 5->2 -> FIRE 1 cycle after elements=2 is sampled, irq_o 1-cycle pulse, sta_o[0]=1, armed_o[0]=0.
2. Count re-arm: cnt_en=1, cnt=3, ch0 in WAIT, 3 xfer pulses -> ARMED after the 3rd pulse edge, counter back to 0; cnt=0 -> re-arm on the first xfer.
3. Status-read re-arm: cnt_en=0, RX-type ch1 th=4 elements=6 -> fires; xfers do nothing; sta_rd_i pulse -> ARMED, then re-fires next edge because the condition still holds.
4. Level mode: ch0 fires and eot_i pulses -> sta_o=3'b101, irq_o held high; clr_i=3'b001 -> sta_o=3'b100, irq_o still 1; clr_i=3'b100 -> irq_o=0; set and clr on the same edge -> bit stays 1.
5. eot_i pulse in pulse mode -> eot_evt_o and irq_o high exactly 1 cycle, 1 cycle later.
6. int_en deasserted during WAIT -> ARMED next edge; HRESETn low for 1 edge during FIRE -> all outputs at reset values on that edge, no further pulse.
